// File: rtl/clk_div_prog.sv
// Programmable clock divider with square, pulse and programmable-duty modes.
// Configuration is double-buffered and applied only on period wrap edges,
// so clk_out never shows a runt high or low phase.
module clk_div_prog #(
   parameter int unsigned CNT_W    = 17,
   parameter int unsigned DEF_DIV  = 100000,
   parameter int unsigned DEF_MODE = 0
) (
   input  logic             clk_in,
   input  logic             rst,
   input  logic             en,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [CNT_W-1:0] cfg_div,
   input  logic [CNT_W-1:0] cfg_duty,
   input  logic [1:0]       cfg_mode,
   output logic             clk_out,
   output logic             tick,
   output logic             cfg_err
);

   typedef enum logic [1:0] {
      MODE_SQUARE  = 2'd0,
      MODE_PULSE   = 2'd1,
      MODE_DUTY    = 2'd2,
      MODE_ILLEGAL = 2'd3
   } mode_t;

   localparam logic [CNT_W-1:0] DEF_N = CNT_W'(DEF_DIV);
   localparam logic [CNT_W-1:0] DEF_H = DEF_N - (DEF_N >> 1);
   localparam mode_t            DEF_M = mode_t'(2'(DEF_MODE));

   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_n_act;
   logic [CNT_W-1:0] r_h_act;
   mode_t            r_mode_act;
   logic [CNT_W-1:0] r_n_pend;
   logic [CNT_W-1:0] r_h_pend;
   mode_t            r_mode_pend;
   logic             r_pending;
   logic             r_clk_out;
   logic             r_tick;
   logic             r_cfg_err;

   logic             w_accept;
   logic             w_illegal;
   logic             w_wrap;
   logic             w_apply;
   logic [CNT_W-1:0] w_h_cfg;
   logic [CNT_W-1:0] w_n_nxt;
   logic [CNT_W-1:0] w_h_nxt;
   mode_t            w_mode_nxt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             w_tick_nxt;
   logic             w_clk_nxt;

   // Handshake decode, wrap detection and next-period values
   always_comb begin
      w_accept   = cfg_valid && !r_pending;
      w_illegal  = (cfg_div < CNT_W'(2)) || (cfg_mode == MODE_ILLEGAL);
      w_h_cfg    = (cfg_mode == MODE_SQUARE) ? (cfg_div - (cfg_div >> 1)) : cfg_duty;
      w_wrap     = (r_cnt == (r_n_act - CNT_W'(1)));
      w_apply    = en && w_wrap && r_pending;
      w_n_nxt    = w_apply ? r_n_pend    : r_n_act;
      w_h_nxt    = w_apply ? r_h_pend    : r_h_act;
      w_mode_nxt = w_apply ? r_mode_pend : r_mode_act;

      // Disabled: park one cycle before wrap so re-enable starts a fresh period
      if (!en) begin
         w_cnt_nxt = r_n_act - CNT_W'(1);
      end else if (w_wrap) begin
         w_cnt_nxt = '0;
      end else begin
         w_cnt_nxt = r_cnt + CNT_W'(1);
      end

      w_tick_nxt = en && (w_cnt_nxt == '0);

      w_clk_nxt = 1'b0;
      if (en) begin
         case (w_mode_nxt)
            MODE_PULSE: w_clk_nxt = w_tick_nxt;
            default:    w_clk_nxt = (w_cnt_nxt < w_h_nxt);
         endcase
      end
   end

   // State, configuration buffers and registered outputs
   always_ff @(posedge clk_in) begin
      if (rst) begin
         r_cnt       <= DEF_N - CNT_W'(1);
         r_n_act     <= DEF_N;
         r_h_act     <= DEF_H;
         r_mode_act  <= DEF_M;
         r_n_pend    <= DEF_N;
         r_h_pend    <= DEF_H;
         r_mode_pend <= DEF_M;
         r_pending   <= 1'b0;
         r_clk_out   <= 1'b0;
         r_tick      <= 1'b0;
         r_cfg_err   <= 1'b0;
      end else begin
         r_cnt      <= w_cnt_nxt;
         r_n_act    <= w_n_nxt;
         r_h_act    <= w_h_nxt;
         r_mode_act <= w_mode_nxt;
         r_clk_out  <= w_clk_nxt;
         r_tick     <= w_tick_nxt;
         r_cfg_err  <= w_accept && w_illegal;
         // Apply and accept are exclusive: accept needs pending low, apply needs it high
         if (w_apply) begin
            r_pending <= 1'b0;
         end else if (w_accept && !w_illegal) begin
            r_pending   <= 1'b1;
            r_n_pend    <= cfg_div;
            r_h_pend    <= w_h_cfg;
            r_mode_pend <= mode_t'(cfg_mode);
         end
      end
   end

   assign cfg_ready = !r_pending;
   assign clk_out   = r_clk_out;
   assign tick      = r_tick;
   assign cfg_err   = r_cfg_err;

endmodule

// File: doc/clk_div_prog.md
CLK_DIV_PROG -- requirements
Module: clk_div_prog

Interface
REQ-001 CNT_W, default 17, width of the period counter and of the divisor and duty fields.
REQ-002 DEF_DIV, default 100000, divisor active after reset (50 MHz in gives 500 Hz out); legal range is 2..2^CNT_W-1.
REQ-003 DEF_MODE, default 0, mode active after reset.
REQ-004 clk_in  input  1  single clock; all logic on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 en  input  1  divider enable.
REQ-007 cfg_valid  input  1  configuration request.
REQ-008 cfg_ready  output  1  high when a new configuration can be accepted.
REQ-009 cfg_div  input  CNT_W  requested divisor N (output period in clk_in cycles).
REQ-010 cfg_duty  input  CNT_W  requested high time H in cycles; used in mode 2 only.
REQ-011 cfg_mode  input  2  0 = square, 1 = pulse, 2 = programmable duty, 3 = illegal.
REQ-012 clk_out  output  1  divided output, driven directly from a flop.
REQ-013 tick  output  1  one-cycle strobe marking the first cycle of every period.
REQ-014 cfg_err  output  1  one-cycle strobe flagging a rejected request.

Function
REQ-015 The block SHALL hold the active registers N_act, H_act, mode_act, the pending registers N_pend, H_pend, mode_pend, a pending flag, and a counter cnt.
REQ-016 Counting (en=1): if cnt==N_act-1 this is a wrap edge and cnt becomes 0; otherwise cnt increments by 1.
REQ-017 On every edge, tick SHALL be set to (next cnt==0) AND en.
REQ-018 Mode 0: H_act SHALL equal N - floor(N/2), so odd N gives a high phase one cycle longer than the low phase.
REQ-019 Mode 0 and mode 2: clk_out SHALL be set to (next cnt < H_act) on every enabled edge.
REQ-020 Mode 1: clk_out SHALL equal tick, i.e. high for exactly one cycle per period.
REQ-021 Mode 2 clamps: H=0 gives clk_out constantly low; H>=N gives clk_out constantly high; tick continues in both cases.
REQ-022 Period: with a constant configuration, clk_out and tick SHALL repeat every N_act cycles exactly, with no drift.
REQ-023 Handshake: cfg_ready SHALL equal NOT pending; a request is accepted on an edge where cfg_valid and cfg_ready are both high.
REQ-024 Rejection: an accepted request with cfg_div<2 or cfg_mode==3 SHALL store nothing, leave pending low, and pulse cfg_err high for one cycle.
REQ-025 Acceptance: a legal request SHALL load the pending registers and set pending.
REQ-026 Apply: on a wrap edge with pending set, the pending values SHALL be copied to the active registers and pending SHALL clear; next cnt, clk_out and tick on that edge SHALL be computed from the new values.
REQ-027 Glitch-free rule: active values SHALL change only on wrap edges, so no runt high or low phase is ever produced.
REQ-028 Simultaneous acceptance and wrap on the same edge: the values SHALL be stored as pending and applied at the following wrap, not the current one.
REQ-029 cfg_valid while cfg_ready is low SHALL be ignored, with no error pulse.
REQ-030 en=0: cnt SHALL be forced to N_act-1 and clk_out and tick driven to 0; requests are still accepted.
REQ-031 Re-enable: the first enabled edge after en=0 SHALL be a wrap edge, so the period restarts cleanly and any pending configuration is applied there.
REQ-032 Latency: the first tick SHALL occur on the first enabled edge after reset or re-enable.

Reset
REQ-033 While rst=1 the block SHALL load N_act=DEF_DIV, H_act as given by DEF_MODE, mode_act=DEF_MODE, cnt=DEF_DIV-1, and clear pending.
REQ-034 While rst=1 the outputs SHALL be clk_out=0, tick=0, cfg_err=0, cfg_ready=1.
REQ-035 Reset asserted mid-period or with a configuration pending SHALL discard the pending configuration and restart from the defaults.

Verification (DEF_DIV=10, CNT_W=8 bench overrides)
REQ-036 Reset release, en=1, mode 0 -> tick every 10 cycles; clk_out high 5 cycles and low 5 cycles; tick coincides with the rising edge of clk_out.
REQ-037 cfg_div=7, mode 0, request in mid-period -> old period completes; from the next wrap, high 4 cycles and low 3 cycles; cfg_ready low from acceptance until the apply edge.
REQ-038 Mode 2 with div=8: duty 3 -> high 3 / low 5; duty 0 -> constantly low; duty 9 -> constantly high; tick present every 8 cycles in all three cases.
REQ-039 cfg_div=1, then cfg_mode=3 -> cfg_err pulses once for each request; period and duty unchanged; pending never set.
REQ-040 Request accepted on a wrap edge -> new values take effect one full period later; also cover en dropped for 4 cycles mid-period (outputs low during the gap, fresh period with tick on re-enable) and rst mid-period with a request pending (defaults restored, pending cleared).
